// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and the
// counter width helper used by the top level.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: computes a - b - c with difference and borrow.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic differ,
    output logic barrow
);

    // Borrow is needed when a is 0 and anything is subtracted, or when both
    // b and c are subtracted regardless of a.
    always_comb begin
        differ = a ^ b ^ c;
        barrow = (~a & (b | c)) | (b & c);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: a - b - bin computed LSB-first, one bit per
// clock, through a single full_sub cell and a registered borrow.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             fs_d;
    logic             fs_b;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    full_sub u_slice (
        .a      (sa[0]),
        .b      (sb[0]),
        .c      (brw),
        .differ (fs_d),
        .barrow (fs_b)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus load/step strobes for the datapath; start is
    // only honoured from IDLE or DONE so a start during RUN is ignored.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand/difference shift registers, borrow, counter and result
    // registers; the result is captured on the edge that processes the last
    // bit so it is already valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            sd   <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            brw <= bin;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= {fs_d, sd[WIDTH-1:1]};
            brw <= fs_b;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                diff <= {fs_d, sd[WIDTH-1:1]};
                bout <= fs_b;
            end
        end
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
        end
    end

endmodule
